stack_pointer_unit: RTL and testbench
=====================================

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of stack pointer and memory address.
REQ-002 SHALL have parameter SP_TOP, default 32'h0000_0FFF, empty-stack reset value.
REQ-003 SHALL have parameter SP_LIMIT, default 32'h0000_0F00, lowest address a push may write.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on falling edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_push  input  1  push request.
REQ-007 SHALL have port i_pop  input  1  pop request.
REQ-008 SHALL have port i_two_words  input  1  request moves 2 words (e.g. 32-bit PC); 0 moves 1 word.
REQ-009 SHALL have port i_load  input  1  direct SP write.
REQ-010 SHALL have port i_load_value  input  ADDR_W  value for i_load.
REQ-011 SHALL have port o_stack_pointer  output  ADDR_W  current SP.
REQ-012 SHALL have port o_mem_addr  output  ADDR_W  address of current beat.
REQ-013 SHALL have port o_mem_valid  output  1  beat active this cycle.
REQ-014 SHALL have port o_busy  output  1  second beat in progress; new requests ignored.
REQ-015 SHALL have port o_overflow  output  1  one-cycle pulse, push rejected.
REQ-016 SHALL have port o_underflow  output  1  one-cycle pulse, pop rejected.

Function
REQ-017 SHALL implement a full-descending stack: push writes at SP then SP-1; pop reads at SP+1 then SP+1.
REQ-018 SHALL use FSM states IDLE and BEAT2; requests are sampled only in IDLE.
REQ-019 SHALL, in IDLE with accepted request, drive o_mem_valid=1 and o_mem_addr combinationally (push: SP; pop: SP+1) in the same cycle.
REQ-020 SHALL, for a one-word request, update SP on the next falling edge and remain in IDLE.
REQ-021 SHALL, for a two-word request, update SP after beat 1, enter BEAT2, assert o_busy and o_mem_valid with the next address, update SP again, then return to IDLE (latency 2 cycles).
REQ-022 SHALL treat i_push and i_pop both high as a no-op: no beat, SP unchanged, no flag.
REQ-023 SHALL give i_load priority over push/pop and BEAT2: SP <= i_load_value next edge, state <= IDLE, no beat.
REQ-024 SHALL reject a push when remaining room (SP - SP_LIMIT + 1) is less than the word count: no beat, SP unchanged, o_overflow pulse.
REQ-025 SHALL reject a pop when entries (SP_TOP - SP) are less than the word count: no beat, SP unchanged, o_underflow pulse.
REQ-026 SHALL check bounds once at acceptance; a two-word op never splits into a rejected half.
REQ-027 SHALL perform all address arithmetic modulo 2^ADDR_W.

Reset
REQ-028 SHALL, on i_reset sampled high, set SP=SP_TOP, state=IDLE, o_busy=0, o_mem_valid=0, o_overflow=0, o_underflow=0; reset overrides load and aborts BEAT2.

Configuration
REQ-029 SHALL compile bounds checking under macro SP_BOUNDS_CHECK_EN: defined -> REQ-024..026 active; undefined -> o_overflow/o_underflow tied 0, all requests accepted, SP wraps modulo 2^ADDR_W.

Structure
REQ-030 SHALL place FSM state encodings (SP_IDLE, SP_BEAT2) and default SP_TOP/SP_LIMIT constants in shared package sp_pkg.
REQ-031 SHALL implement the room/entry comparison in one sub-module sp_bounds_check (combinational), instantiated only when SP_BOUNDS_CHECK_EN is defined.

Verification
REQ-032 Reset then one-word push -> o_mem_addr=0xFFF, o_mem_valid=1, SP=0xFFE next cycle.
REQ-033 Two-word push from 0xFFF -> beat addrs 0xFFF then 0xFFE, o_busy high in cycle 2, SP=0xFFD; push asserted in cycle 2 ignored.
REQ-034 Pop at SP=0xFFF -> no beat, o_underflow=1 one cycle, SP stays 0xFFF (macro defined); without macro, addr 0x1000, SP=0x1000.
REQ-035 Load 0xF00 then two-word push -> o_overflow=1, no beat, SP=0xF00; one-word push -> addr 0xF00, SP=0xEFF.
REQ-036 i_load=0x800 during BEAT2 -> BEAT2 aborted, SP=0x800, o_busy=0 next cycle; i_reset during BEAT2 -> SP=0xFFF, IDLE.
REQ-037 i_push and i_pop both high at SP=0xFF0 -> o_mem_valid=0, SP unchanged, no flags.

Source files
------------

// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared FSM encodings and default stack bounds for stack_pointer_unit
package sp_pkg;

    typedef enum logic {
        SP_IDLE  = 1'b0,
        SP_BEAT2 = 1'b1
    } sp_state_t;

    localparam logic [31:0] SP_TOP_DEFAULT   = 32'h0000_0FFF;
    localparam logic [31:0] SP_LIMIT_DEFAULT = 32'h0000_0F00;

endpackage

// File: rtl/sp_bounds_check.sv
// rtl/sp_bounds_check.sv - combinational room/entry test for a 1- or 2-word stack request
//
// Ports:
//   sp        current stack pointer
//   two_words request size (1: two words, 0: one word)
//   push_ok   enough room below SP for the push
//   pop_ok    enough entries above SP for the pop
module sp_bounds_check
    import sp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SP_TOP   = ADDR_W'(SP_TOP_DEFAULT),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
    input  logic [ADDR_W-1:0] sp,
    input  logic              two_words,
    output logic              push_ok,
    output logic              pop_ok
);

    logic [ADDR_W-1:0] words;
    logic [ADDR_W-1:0] room;
    logic [ADDR_W-1:0] entries;

    // Both differences wrap modulo 2^ADDR_W, so an SP loaded outside the
    // window yields a large (permissive) value rather than a negative one.
    assign words   = two_words ? ADDR_W'(2) : ADDR_W'(1);
    assign room    = sp - SP_LIMIT + ADDR_W'(1);
    assign entries = SP_TOP - sp;
    assign push_ok = (room >= words);
    assign pop_ok  = (entries >= words);

endmodule

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - full-descending stack pointer with 1/2-word push/pop beats
//
// Optional feature: define SP_BOUNDS_CHECK_EN to reject pushes/pops that
// would cross SP_LIMIT / SP_TOP (o_overflow / o_underflow pulses). Without
// it every request is accepted and SP wraps.
//
// Ports:
//   i_clk           clock; all state changes on the falling edge
//   i_reset         synchronous active-high reset
//   i_push, i_pop   requests (both high = no-op)
//   i_two_words     request moves two words instead of one
//   i_load          direct SP write, beats everything except reset
//   i_load_value    value written by i_load
//   o_stack_pointer current SP
//   o_mem_addr      address of the current beat
//   o_mem_valid     a beat is active this cycle
//   o_busy          second beat in progress, requests ignored
//   o_overflow      rejected push (same cycle as the request)
//   o_underflow     rejected pop (same cycle as the request)
module stack_pointer_unit
    import sp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SP_TOP   = ADDR_W'(SP_TOP_DEFAULT),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_two_words,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_value,
    output logic [ADDR_W-1:0] o_stack_pointer,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_valid,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_underflow
);

    sp_state_t         state;
    sp_state_t         next_state;
    logic [ADDR_W-1:0] sp;
    logic              pop_dir;      // direction of the op whose second beat is pending
    logic              quiet;        // reset or load suppresses any beat this cycle
    logic              req_push;
    logic              req_pop;
    logic              push_ok;
    logic              pop_ok;
    logic              accept_push;
    logic              accept_pop;
    logic              beat2_active;
    logic              inc_sp;
    logic              dec_sp;

    assign quiet    = i_reset | i_load;
    assign req_push = i_push & ~i_pop & ~quiet & (state == SP_IDLE);
    assign req_pop  = i_pop & ~i_push & ~quiet & (state == SP_IDLE);

`ifdef SP_BOUNDS_CHECK_EN
    sp_bounds_check #(
        .ADDR_W   (ADDR_W),
        .SP_TOP   (SP_TOP),
        .SP_LIMIT (SP_LIMIT)
    ) u_bounds (
        .sp        (sp),
        .two_words (i_two_words),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok)
    );
    assign o_overflow  = req_push & ~push_ok;
    assign o_underflow = req_pop & ~pop_ok;
`else
    assign push_ok     = 1'b1;
    assign pop_ok      = 1'b1;
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

    assign accept_push  = req_push & push_ok;
    assign accept_pop   = req_pop & pop_ok;
    assign beat2_active = (state == SP_BEAT2) & ~quiet;
    assign inc_sp       = accept_pop | (beat2_active & pop_dir);
    assign dec_sp       = accept_push | (beat2_active & ~pop_dir);

    // State register
    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            state <= SP_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (quiet) begin
            next_state = SP_IDLE;
        end else begin
            case (state)
                SP_IDLE:  if ((accept_push | accept_pop) & i_two_words) next_state = SP_BEAT2;
                SP_BEAT2: next_state = SP_IDLE;
                default:  next_state = SP_IDLE;
            endcase
        end
    end

    // Outputs: pops address SP+1 on both beats because SP has already moved
    // up by one when the second beat is presented.
    always_comb begin
        o_busy      = (state == SP_BEAT2);
        o_mem_valid = accept_push | accept_pop | beat2_active;
        o_mem_addr  = inc_sp ? sp + ADDR_W'(1) : sp;
    end

    // SP datapath
    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            sp      <= SP_TOP;
            pop_dir <= 1'b0;
        end else if (i_load) begin
            sp <= i_load_value;
        end else begin
            if (inc_sp) begin
                sp <= sp + ADDR_W'(1);
            end else if (dec_sp) begin
                sp <= sp - ADDR_W'(1);
            end
            if (accept_push | accept_pop) begin
                pop_dir <= accept_pop;
            end
        end
    end

    assign o_stack_pointer = sp;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb/tb_stack_pointer_unit.sv - scoreboard bench for stack_pointer_unit
module tb_stack_pointer_unit;

    localparam logic [31:0] TOP   = 32'h0000_0FFF;
    localparam logic [31:0] LIMIT = 32'h0000_0F00;

    logic        i_clk = 1'b0;
    logic        i_reset, i_push, i_pop, i_two_words, i_load;
    logic [31:0] i_load_value;
    logic [31:0] o_stack_pointer, o_mem_addr;
    logic        o_mem_valid, o_busy, o_overflow, o_underflow;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        busy;
        logic        ovf;
        logic        unf;
        logic [31:0] sp;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] m_sp;
    logic        m_busy;
    logic        m_pop;

    stack_pointer_unit dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_push          (i_push),
        .i_pop           (i_pop),
        .i_two_words     (i_two_words),
        .i_load          (i_load),
        .i_load_value    (i_load_value),
        .o_stack_pointer (o_stack_pointer),
        .o_mem_addr      (o_mem_addr),
        .o_mem_valid     (o_mem_valid),
        .o_busy          (o_busy),
        .o_overflow      (o_overflow),
        .o_underflow     (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive at posedge, predict, sample 1ns later (state moves on negedge).
    task automatic step(input logic rst, input logic push, input logic pop,
                        input logic two, input logic load, input logic [31:0] lv);
        exp_t        e;
        exp_t        g;
        logic [31:0] words;
        logic        ok;
        @(posedge i_clk);
        i_reset = rst; i_push = push; i_pop = pop;
        i_two_words = two; i_load = load; i_load_value = lv;

        e = '0;
        e.sp   = m_sp;
        e.busy = m_busy;
        words  = two ? 32'd2 : 32'd1;
        if (rst) begin
            m_sp = TOP; m_busy = 1'b0;
        end else if (load) begin
            m_sp = lv; m_busy = 1'b0;
        end else if (m_busy) begin
            e.valid = 1'b1;
            e.addr  = m_pop ? m_sp + 32'd1 : m_sp;
            m_sp    = m_pop ? m_sp + 32'd1 : m_sp - 32'd1;
            m_busy  = 1'b0;
        end else if (push ^ pop) begin
            ok = 1'b1;
`ifdef SP_BOUNDS_CHECK_EN
            if (push && (m_sp - LIMIT + 32'd1) < words) begin ok = 1'b0; e.ovf = 1'b1; end
            if (pop && (TOP - m_sp) < words)            begin ok = 1'b0; e.unf = 1'b1; end
`endif
            if (ok) begin
                e.valid = 1'b1;
                e.addr  = push ? m_sp : m_sp + 32'd1;
                m_sp    = push ? m_sp - 32'd1 : m_sp + 32'd1;
                m_busy  = two;
                m_pop   = pop;
            end
        end
        sb.push_back(e);

        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            check("sp",    o_stack_pointer, g.sp);
            check("valid", {31'd0, o_mem_valid}, {31'd0, g.valid});
            check("busy",  {31'd0, o_busy}, {31'd0, g.busy});
            check("ovf",   {31'd0, o_overflow}, {31'd0, g.ovf});
            check("unf",   {31'd0, o_underflow}, {31'd0, g.unf});
            if (g.valid) check("addr", o_mem_addr, g.addr);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        i_reset = 1'b1; i_push = 1'b0; i_pop = 1'b0;
        i_two_words = 1'b0; i_load = 1'b0; i_load_value = '0;
        repeat (2) @(posedge i_clk);
        m_sp = TOP; m_busy = 1'b0; m_pop = 1'b0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        idle();
        check("reset_sp", o_stack_pointer, 32'h0FFF);

        // one-word push
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("push1_addr", o_mem_addr, 32'h0FFF);
        idle();
        check("push1_sp", o_stack_pointer, 32'h0FFE);

        // two-word push; push held in beat 2 is ignored
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("push2_b1", o_mem_addr, 32'h0FFF);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        check("push2_b2", o_mem_addr, 32'h0FFE);
        check("push2_busy", {31'd0, o_busy}, 32'd1);
        idle();
        check("push2_sp", o_stack_pointer, 32'h0FFD);

        // pop on empty stack
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle();
`ifdef SP_BOUNDS_CHECK_EN
        check("empty_pop_sp", o_stack_pointer, 32'h0FFF);
`else
        check("empty_pop_sp", o_stack_pointer, 32'h1000);
`endif

        // limit: two-word then one-word push at SP_LIMIT
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0F00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        if (m_busy) idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0F00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("limit_addr", o_mem_addr, 32'h0F00);
        idle();
        check("limit_sp", o_stack_pointer, 32'h0EFF);

        // push+pop together is a no-op
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0FF0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        check("both_valid", {31'd0, o_mem_valid}, 32'd0);
        idle();
        check("both_sp", o_stack_pointer, 32'h0FF0);

        // two-word pop: both beats at SP+1
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("pop2_b1", o_mem_addr, 32'h0FF1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("pop2_b2", o_mem_addr, 32'h0FF2);
        idle();
        check("pop2_sp", o_stack_pointer, 32'h0FF2);

        // load aborts BEAT2
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0800);
        idle();
        check("abort_load_sp", o_stack_pointer, 32'h0800);
        check("abort_load_busy", {31'd0, o_busy}, 32'd0);

        // reset aborts BEAT2
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        idle();
        check("abort_rst_sp", o_stack_pointer, 32'h0FFF);

        // random traffic around the window
        for (int i = 0; i < 400; i++) begin
            logic [31:0] lv;
            lv = 32'h0EF8 + 32'($urandom_range(0, 16'h110));
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), lv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
